// File: rtl/score_text_formatter_pkg.sv
// Shared text constants, FSM state encoding and sizing helper for the score formatter.
package score_text_formatter_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    FORMAT
  } fmt_state_t;

  // Decimal digits of 2^width-1: 1 + floor(width*log10(2)).
  // 2^width is never a power of ten for width > 0, so it has the same
  // digit count as 2^width-1.
  function automatic int unsigned digits_needed(input int unsigned width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/score_text_formatter_bcd_nibble_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_nibble_adjust (
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/score_text_formatter.sv
// Sequential binary-to-ASCII decimal formatter (double-dabble, one bit per cycle)
// producing a right-aligned, optionally blank-padded string for the renderers.
module score_text_formatter
  import score_text_formatter_pkg::*;
#(
  parameter int unsigned BIN_WIDTH     = 16,
  parameter int unsigned NUM_DIGITS    = 5,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [BIN_WIDTH-1:0]            value,
  output logic                            busy,
  output logic                            done,
  output logic [0:NUM_DIGITS-1][7:0]      chars
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

  if (NUM_DIGITS < digits_needed(BIN_WIDTH)) begin : g_size_check
    $error("score_text_formatter: NUM_DIGITS too small for BIN_WIDTH");
  end

  fmt_state_t              state;
  logic [BIN_WIDTH-1:0]    shift;
  logic [BCD_W-1:0]        bcd;
  logic [BCD_W-1:0]        bcd_adj;
  logic [CNT_W-1:0]        count;

  logic [0:NUM_DIGITS-1][7:0] text;
  logic [0:NUM_DIGITS-1][7:0] reset_text;
  logic [NUM_DIGITS:0]        lead;

  assign lead[0] = BLANK_LEADING;

  // Position i (0 = leftmost) reads nibble NUM_DIGITS-1-i; the blanking flag
  // ripples left to right and is forced off at the rightmost position.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [3:0] nib;
    logic       blank;

    assign nib = bcd[4*(NUM_DIGITS-1-i) +: 4];

    bcd_nibble_adjust u_adj (
      .nibble   (bcd[4*i +: 4]),
      .adjusted (bcd_adj[4*i +: 4])
    );

    assign blank       = lead[i] && (nib == 4'd0) && (i != NUM_DIGITS - 1);
    assign lead[i+1]   = blank;
    assign text[i]     = blank ? ASCII_SPACE : (ASCII_ZERO + {4'h0, nib});
    assign reset_text[i] = (BLANK_LEADING && (i != NUM_DIGITS - 1)) ? ASCII_SPACE : ASCII_ZERO;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shift <= '0;
      bcd   <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      chars <= reset_text;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift <= value;
            bcd   <= '0;
            count <= CNT_W'(BIN_WIDTH);
            busy  <= 1'b1;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          // Bits shifted out above the BCD register are always zero given the size check.
          {bcd, shift} <= {bcd_adj, shift} << 1;
          count        <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= FORMAT;
          end
        end
        FORMAT: begin
          chars <= text;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_text_formatter.sv
// Directed, table-driven bench for score_text_formatter (default and zero-padded variants).
module tb_score_text_formatter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [15:0] value_a, value_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [0:4][7:0] chars_a, chars_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_text_formatter dut_a (
    .clk   (clk),
    .reset (reset),
    .start (start_a),
    .value (value_a),
    .busy  (busy_a),
    .done  (done_a),
    .chars (chars_a)
  );

  score_text_formatter #(
    .BIN_WIDTH     (16),
    .NUM_DIGITS    (5),
    .BLANK_LEADING (1'b0)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .start (start_b),
    .value (value_b),
    .busy  (busy_b),
    .done  (done_b),
    .chars (chars_b)
  );

  typedef struct {
    bit          sel;
    logic [15:0] value;
    logic [39:0] expect_text;
  } vec_t;

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" (%h), expected \"%s\" (%h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [39:0] cur_chars(input bit sel);
    return sel ? chars_b : chars_a;
  endfunction

  // Waits (bounded) for done on the chosen instance; n = edges waited, -1 on timeout.
  task automatic wait_done(input bit sel, output int n, output bit early_change);
    logic [39:0] c0;
    c0 = cur_chars(sel);
    n = -1;
    early_change = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (sel ? done_b : done_a) begin
        n = k;
        break;
      end
      if (cur_chars(sel) !== c0) early_change = 1'b1;
    end
  endtask

  task automatic convert(input bit sel, input logic [15:0] v, input logic [39:0] exp, input string name);
    int  n;
    bit  early;
    if (sel) begin start_b = 1'b1; value_b = v; end
    else     begin start_a = 1'b1; value_a = v; end
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    check_int({name, " busy after accept"}, int'(sel ? busy_b : busy_a), 1);
    // Changing value after acceptance must not matter.
    if (sel) value_b = ~v; else value_a = ~v;
    wait_done(sel, n, early);
    check_int({name, " done latency"}, n, 17);
    check_int({name, " chars held before done"}, int'(early), 0);
    check_str({name, " chars"}, cur_chars(sel), exp);
    check_int({name, " busy at done"}, int'(sel ? busy_b : busy_a), 0);
    @(posedge clk); #1;
    check_int({name, " done one cycle"}, int'(sel ? done_b : done_a), 0);
  endtask

  initial begin
    vec_t vecs[$];
    int   n, n2, dones;
    bit   early;

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; value_a = '0; value_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_str("reset chars a", chars_a, "    0");
    check_int("reset busy a", int'(busy_a), 0);
    check_int("reset done a", int'(done_a), 0);
    check_str("reset chars b", chars_b, "00000");
    reset = 1'b0;
    @(posedge clk); #1;

    vecs.push_back('{1'b0, 16'd65535, "65535"});
    vecs.push_back('{1'b0, 16'd1234,  " 1234"});
    vecs.push_back('{1'b0, 16'd0,     "    0"});
    vecs.push_back('{1'b0, 16'd9,     "    9"});
    vecs.push_back('{1'b0, 16'd10,    "   10"});
    vecs.push_back('{1'b0, 16'd1000,  " 1000"});
    vecs.push_back('{1'b0, 16'd40960, "40960"});
    vecs.push_back('{1'b1, 16'd42,    "00042"});
    vecs.push_back('{1'b1, 16'd10,    "00010"});
    vecs.push_back('{1'b1, 16'd0,     "00000"});
    vecs.push_back('{1'b1, 16'd50505, "50505"});
    foreach (vecs[i])
      convert(vecs[i].sel, vecs[i].value, vecs[i].expect_text, $sformatf("vec%0d", i));

    // Back-to-back: start held while done is high is accepted on that edge.
    start_a = 1'b1; value_a = 16'd1234;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done(1'b0, n, early);
    check_int("b2b first latency", n, 17);
    check_str("b2b first chars", chars_a, " 1234");
    start_a = 1'b1; value_a = 16'd0;
    @(posedge clk); #1;
    start_a = 1'b0;
    check_int("b2b second accepted", int'(busy_a), 1);
    wait_done(1'b0, n2, early);
    check_int("b2b accept spacing", n2 + 1, 18);
    check_str("b2b second chars", chars_a, "    0");
    @(posedge clk); #1;

    // Start during conversion is ignored.
    start_a = 1'b1; value_a = 16'd999;
    @(posedge clk); #1;
    start_a = 1'b0;
    dones = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin start_a = 1'b1; value_a = 16'd111; end
      if (k == 6) start_a = 1'b0;
      @(posedge clk); #1;
      if (done_a) dones++;
    end
    check_int("ignored start done count", dones, 1);
    check_str("ignored start chars", chars_a, "  999");

    // Reset mid-conversion discards the result and restores reset values.
    start_a = 1'b1; value_a = 16'd50000;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_int("midreset busy", int'(busy_a), 0);
    check_int("midreset done", int'(done_a), 0);
    check_str("midreset chars", chars_a, "    0");
    dones = 0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      if (done_a) dones++;
    end
    check_int("midreset no done", dones, 0);
    convert(1'b0, 16'd7, "    7", "after reset");

    // Reset and start together: reset wins.
    reset = 1'b1; start_a = 1'b1; value_a = 16'd321;
    @(posedge clk); #1;
    reset = 1'b0; start_a = 1'b0;
    check_int("reset+start busy", int'(busy_a), 0);
    dones = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done_a) dones++;
    end
    check_int("reset+start no done", dones, 0);
    check_str("reset+start chars", chars_a, "    0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
